mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/md_arith.sv | 59 +++++
 rtl/mdu_ctrl.sv | 95 +++++++++
 tb/tb_mdu_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mdu_pkg;

  // Instruction selector carried on the op port; codes 6 and 7 do nothing.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Multi-cycle operations (mult/multu/div/divu) all have op[2] clear.
  function automatic logic is_md_op(input logic [2:0] op);
    return !op[2];
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 multiply / divide producing a 64-bit {HI,LO} result.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result follows the inputs.
// Ports: i_op selects the operation, i_a/i_b are the operands,
//        o_res is {HI,LO}, o_div_zero flags a zero divisor.
module md_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_res,
  output logic        o_div_zero
);

  logic signed [63:0] w_sprod;
  logic [63:0]        w_uprod;
  logic [31:0]        w_udvsr;
  logic [31:0]        w_uq;
  logic [31:0]        w_ur;
  logic [31:0]        w_abs_a;
  logic [31:0]        w_abs_b;
  logic [31:0]        w_qmag;
  logic [31:0]        w_rmag;
  logic [31:0]        w_sq;
  logic [31:0]        w_sr;

  assign o_div_zero = (i_b == 32'd0);

  assign w_sprod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

  // A zero divisor is replaced by 1 so the datapath never divides by zero;
  // the controller discards that result anyway.
  assign w_udvsr = o_div_zero ? 32'd1 : i_b;
  assign w_uq    = i_a / w_udvsr;
  assign w_ur    = i_a % w_udvsr;

  // Signed divide on magnitudes: avoids the 0x80000000 / -1 overflow case
  // (magnitude 0x80000000 negates back to itself, giving the wrapped quotient).
  assign w_abs_a = i_a[31] ? -i_a : i_a;
  assign w_abs_b = i_b[31] ? -i_b : w_udvsr;
  assign w_qmag  = w_abs_a / w_abs_b;
  assign w_rmag  = w_abs_a % w_abs_b;
  assign w_sq    = (i_a[31] ^ i_b[31]) ? -w_qmag : w_qmag;
  assign w_sr    = i_a[31] ? -w_rmag : w_rmag;

  always_comb begin
    o_res = 64'd0;
    case (op_e'(i_op))
      OP_MULT:  o_res = w_sprod;
      OP_MULTU: o_res = w_uprod;
      OP_DIV:   o_res = {w_sr, w_sq};
      OP_DIVU:  o_res = {w_ur, w_uq};
      default:  o_res = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: IDLE/BUSY FSM, countdown, pending result, HI/LO.
// Latency: mult N=MULT_CYCLES, div N=DIV_CYCLES busy cycles; HI/LO visible after; mthi/mtlo next cycle.
// Backpressure: stall freezes the front end while a D-stage MDU instruction meets a busy unit.
// Ports: clk, reset (async active-low), start/op/a/b from E stage, d_md from D stage;
//        busy, stall, hi, lo outputs.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_pend;
  logic             r_pend_wr;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic [63:0]      w_res;
  logic             w_div_zero;
  logic             w_md_start;

  md_arith u_arith (
    .i_op       (op),
    .i_a        (a),
    .i_b        (b),
    .o_res      (w_res),
    .o_div_zero (w_div_zero)
  );

  assign w_md_start = start & is_md_op(op);

  assign busy  = (r_state == ST_BUSY);
  assign stall = d_md & (busy | w_md_start);
  assign hi    = r_hi;
  assign lo    = r_lo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pend    <= '0;
      r_pend_wr <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_md_start) begin
            r_pend    <= w_res;
            // Divide by zero still occupies the unit but must not touch HI/LO.
            r_pend_wr <= !(op[1] & w_div_zero);
            r_cnt     <= op[1] ? DIV_LD : MULT_LD;
            r_state   <= ST_BUSY;
          end else if (start && op == OP_MTHI) begin
            r_hi <= a;
          end else if (start && op == OP_MTLO) begin
            r_lo <= a;
          end
        end
        ST_BUSY: begin
          // New starts are ignored here; only the countdown advances.
          if (r_cnt == '0) begin
            if (r_pend_wr) begin
              r_hi <= r_pend[63:32];
              r_lo <= r_pend[31:0];
            end
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with hand-computed expected values.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk;
  int n_err;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .d_md  (d_md),
    .busy  (busy),
    .stall (stall),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [2:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input logic dm);
    start = st;
    op    = o;
    a     = aa;
    b     = bb;
    d_md  = dm;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called one cycle after a start edge: expects n busy cycles, then idle.
  task automatic run_busy(input string tag, input int n, input logic dm, input logic exp_stall);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_stall"}, {31'd0, stall}, {31'd0, exp_stall});
      step();
    end
    chk({tag, "_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_stall_end"}, {31'd0, stall}, 32'd0);
    d_md = dm;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // mult -1 * 2 with d_md held high: stall for start cycle + 5 busy cycles.
    drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd2, 1'b1);
    #1;
    chk("mult_stall_start", {31'd0, stall}, 32'd1);
    step();
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b1);
    chk("mult_hi_hidden", hi, 32'd0);
    run_busy("mult", 5, 1'b0, 1'b1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);

    // multu with d_md low: stall never asserts.
    drive(1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    #1;
    chk("multu_stall_start", {31'd0, stall}, 32'd0);
    step();
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
    run_busy("multu", 5, 1'b0, 1'b0);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // div -7 / 2 -> q=-3, r=-1.
    drive(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    step();
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
    run_busy("div", 10, 1'b0, 1'b0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // divu by zero: full busy period, HI/LO untouched.
    drive(1'b1, 3'd3, 32'd1234, 32'd0, 1'b0);
    step();
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
    run_busy("divu0", 10, 1'b0, 1'b0);
    chk("divu0_lo", lo, 32'hFFFF_FFFD);
    chk("divu0_hi", hi, 32'hFFFF_FFFF);

    // Overflow case of signed divide.
    drive(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    step();
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
    run_busy("divovf", 10, 1'b0, 1'b0);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);

    // divu 100 / 7 -> q=14, r=2.
    drive(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
    step();
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
    run_busy("divu", 10, 1'b0, 1'b0);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // mthi / mtlo: immediate write, no busy period.
    drive(1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b1);
    #1;
    chk("mthi_stall", {31'd0, stall}, 32'd0);
    step();
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_lo_kept", lo, 32'd14);
    drive(1'b1, 3'd5, 32'hCAFE_0001, 32'd0, 1'b0);
    step();
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
    chk("mtlo_lo", lo, 32'hCAFE_0001);
    chk("mtlo_hi_kept", hi, 32'h1234_5678);

    // op 7 with start: nothing happens.
    drive(1'b1, 3'd7, 32'hDEAD_BEEF, 32'd3, 1'b1);
    #1;
    chk("nop_stall", {31'd0, stall}, 32'd0);
    step();
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_hi", hi, 32'h1234_5678);
    chk("nop_lo", lo, 32'hCAFE_0001);

    // mult 3*4; starts during BUSY (mthi, then mult 7*7) are ignored.
    drive(1'b1, 3'd0, 32'd3, 32'd4, 1'b0);
    step();
    drive(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
    chk("ign_busy1", {31'd0, busy}, 32'd1);
    step();
    drive(1'b1, 3'd0, 32'd7, 32'd7, 1'b0);
    chk("ign_hi_kept", hi, 32'h1234_5678);
    chk("ign_busy2", {31'd0, busy}, 32'd1);
    step();
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
    chk("ign_busy3", {31'd0, busy}, 32'd1);
    step();
    chk("ign_busy4", {31'd0, busy}, 32'd1);
    step();
    chk("ign_busy5", {31'd0, busy}, 32'd1);
    step();
    chk("ign_done", {31'd0, busy}, 32'd0);
    chk("ign_lo", lo, 32'd12);
    chk("ign_hi", hi, 32'd0);
    drive(1'b1, 3'd4, 32'hA5A5_A5A5, 32'd0, 1'b0);
    step();
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b0);

    // Reset in the 3rd busy cycle of a div: result discarded.
    drive(1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
    step();
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
    step();
    step();
    chk("rstmid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b1);
    #1;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    chk("rstmid_stall_idle", {31'd0, stall}, 32'd0);
    drive(1'b1, 3'd0, 32'd1, 32'd1, 1'b1);
    #1;
    chk("rstmid_stall_md", {31'd0, stall}, 32'd1);
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("rstmid_no_busy", {31'd0, busy}, 32'd0);
    end
    chk("rstmid_no_commit_lo", lo, 32'd0);
    chk("rstmid_no_commit_hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
